// File: rtl/pipe_ex_mem_stage.sv
// pipe_ex_mem_stage
// -----------------
// EX/MEM pipeline stage. The store byte mask, the lane-aligned store data and
// the misalignment flag are computed from the incoming address and funct3.
// They are registered together with the beat.
//
// Parameters
//   XLEN       datapath width, 32 or 64
//   PAYLOAD_W  width of the opaque pass-through bundle
//   SKID       1: two-entry skid buffer, in_ready comes from a register
//              0: single register, in_ready = out_ready || !out_valid
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   i_flush             drop every held beat and the beat presented this cycle
//   i_in_valid/o_in_ready, i_in_payload, i_in_is_store, i_in_funct3,
//   i_in_addr, i_in_wdata                        upstream beat
//   o_out_valid/i_out_ready, o_out_payload, o_out_addr, o_out_wdata,
//   o_out_wmask, o_out_misaligned                downstream beat
//   o_dbg_state         FSM state (0 EMPTY, 1 ONE, 2 TWO)
//
// Handshake: a beat moves across an interface on a rising clock edge where
// valid and ready are both high. A producer holding valid keeps its data
// stable until the beat is taken. The outputs stay stable while out_valid is
// high and out_ready is low. i_flush has priority over both transfers. rst
// also drops every beat.
module pipe_ex_mem_stage #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 96,
  parameter int SKID      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [PAYLOAD_W-1:0] i_in_payload,
  input  logic                 i_in_is_store,
  input  logic [2:0]           i_in_funct3,
  input  logic [XLEN-1:0]      i_in_addr,
  input  logic [XLEN-1:0]      i_in_wdata,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [PAYLOAD_W-1:0] o_out_payload,
  output logic [XLEN-1:0]      o_out_addr,
  output logic [XLEN-1:0]      o_out_wdata,
  output logic [XLEN/8-1:0]    o_out_wmask,
  output logic                 o_out_misaligned,
  output logic [1:0]           o_dbg_state
);

  localparam int NB    = XLEN / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int ENT_W = PAYLOAD_W + 2 * XLEN + NB + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Store lane computation on the incoming beat
  // ---------------------------------------------------------------------------
  logic [OFFW-1:0]  w_off;
  logic [OFFW-1:0]  w_align;   // low offset bits that must be zero for this size
  logic [7:0]       w_base;    // mask of the access width before shifting
  logic             w_size_ok; // access width fits the datapath
  logic [NB-1:0]    w_wmask;
  logic [XLEN-1:0]  w_wdata;
  logic             w_mis;
  logic [ENT_W-1:0] w_in_ent;

  assign w_off = i_in_addr[OFFW-1:0];

  always_comb begin
    w_base    = 8'hFF;
    w_align   = '1;
    w_size_ok = 1'b1;
    case (i_in_funct3[1:0])
      2'b00: begin w_base = 8'h01; w_align = OFFW'(0); end
      2'b01: begin w_base = 8'h03; w_align = OFFW'(1); end
      2'b10: begin w_base = 8'h0F; w_align = OFFW'(3); end
      default: begin
        w_base    = 8'hFF;
        w_align   = OFFW'(7);
        w_size_ok = (XLEN == 64);
      end
    endcase
  end

  // Non-stores and misaligned stores keep the data unshifted and the mask empty.
  always_comb begin
    w_mis   = 1'b0;
    w_wmask = '0;
    w_wdata = i_in_wdata;
    if (i_in_is_store) begin
      if (!w_size_ok || ((w_off & w_align) != '0)) begin
        w_mis = 1'b1;
      end else begin
        w_wmask = w_base[NB-1:0] << w_off;
        w_wdata = i_in_wdata << {w_off, 3'b000};
      end
    end
  end

  assign w_in_ent = {i_in_payload, i_in_addr, w_wdata, w_wmask, w_mis};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [ENT_W-1:0] r_main;
  logic [ENT_W-1:0] r_skid;
  logic             w_acc;
  logic             w_drn;
  logic             w_ld_main_in;
  logic             w_ld_main_skid;
  logic             w_ld_skid;
  logic             w_clr;

  assign o_out_valid = (r_state != ST_EMPTY);
  assign o_dbg_state = r_state;
  assign w_acc       = i_in_valid && o_in_ready;
  assign w_drn       = o_out_valid && i_out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr          = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_drn) begin
            w_ld_main_in = 1'b1;
          end else if (w_acc && (SKID != 0)) begin
            // The main entry is still owed downstream, so the new beat parks in the skid entry.
            w_state_nxt = ST_TWO;
            w_ld_skid   = 1'b1;
          end else if (w_drn) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drn) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_main <= '0;
        r_skid <= '0;
      end else begin
        if (w_ld_main_in) begin
          r_main <= w_in_ent;
        end else if (w_ld_main_skid) begin
          r_main <= r_skid;
        end
        if (w_ld_skid) begin
          r_skid <= w_in_ent;
        end
      end
    end
  end

  assign {o_out_payload, o_out_addr, o_out_wdata, o_out_wmask, o_out_misaligned} = r_main;

  // ---------------------------------------------------------------------------
  // in_ready
  // ---------------------------------------------------------------------------
  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;
      // Registered from the next state, so there is no combinational path from i_out_ready.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_TWO);
        end
      end
      assign o_in_ready = r_in_ready && !rst;
    end else begin : g_noskid
      assign o_in_ready = !rst && (i_out_ready || (r_state == ST_EMPTY));
    end
  endgenerate

endmodule
